// File: rtl/mem_responder.sv
// mem_responder: synchronous SRAM-style responder behind active-low strobes.
// A four-state FSM (IDLE, RD, WR1, WR2) decodes CE/OE/WE. A write commits only
// after WE has been low for two consecutive sampled cycles. Reads register the
// addressed word into Data_out on every cycle spent in RD.
// Optional build macro: MEM_RESPONDER_BYTE_EN enables UB/LB byte-lane masking
// for both writes and reads. DATA_W must stay 16 in that build.
// Storage is not reset.
module mem_responder #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 16
) (
    input  logic              Clk,
    input  logic              Reset_n,
    input  logic              Mem_CE,
    input  logic              Mem_OE,
    input  logic              Mem_WE,
    input  logic              Mem_UB,
    input  logic              Mem_LB,
    input  logic [15:0]       Mem_addr,
    input  logic [DATA_W-1:0] Data_in,
    output logic [DATA_W-1:0] Data_out,
    output logic              Rd_valid,
    output logic              Wr_done,
    output logic              Mem_err
);

    typedef enum logic [1:0] {IDLE, RD, WR1, WR2} state_t;

    localparam int DEPTH = 1 << ADDR_W;

    state_t            state;
    logic [DATA_W-1:0] mem [0:DEPTH-1];

    // Decoded strobes. A write request takes priority over a read request.
    logic              wr_req;
    logic              rd_req;
    logic              conflict;
    logic              commit;
    logic [ADDR_W-1:0] word;
    logic [DATA_W-1:0] rd_data;

    assign wr_req   = ~Mem_CE & ~Mem_WE;
    assign rd_req   = ~Mem_CE & ~Mem_OE & Mem_WE;
    assign conflict = ~Mem_CE & ~Mem_OE & ~Mem_WE;
    // Upper address bits are dropped, so addresses alias modulo DEPTH.
    assign word     = Mem_addr[ADDR_W-1:0];
    // The second consecutive WE-low cycle is the commit edge. Asserting reset
    // forces IDLE asynchronously, so a pending write can never commit.
    assign commit   = (state == WR1) & wr_req;

`ifdef MEM_RESPONDER_BYTE_EN
    logic [1:0] lane_en;
    assign lane_en = {~Mem_UB, ~Mem_LB};

    // Any lane whose enable is inactive reads back as 0x00.
    always_comb begin
        rd_data = mem[word];
        if (!lane_en[1]) rd_data[15:8] = 8'h00;
        if (!lane_en[0]) rd_data[7:0]  = 8'h00;
    end

    // Write only the enabled byte lanes of the addressed word.
    always_ff @(posedge Clk) begin
        if (commit) begin
            for (int b = 0; b < 2; b++) begin
                if (lane_en[b]) mem[word][b*8 +: 8] <= Data_in[b*8 +: 8];
            end
        end
    end
`else
    // UB and LB are ignored. Reads always return the full word.
    assign rd_data = mem[word];

    // Write the full word on the commit edge.
    always_ff @(posedge Clk) begin
        if (commit) mem[word] <= Data_in;
    end
`endif

    // FSM with registered outputs.
    // Rd_valid tracks RD, Wr_done tracks WR2, and Mem_err flags any sampled
    // OE/WE collision.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state    <= IDLE;
            Data_out <= '0;
            Rd_valid <= 1'b0;
            Wr_done  <= 1'b0;
            Mem_err  <= 1'b0;
        end else begin
            Mem_err  <= conflict;
            Rd_valid <= 1'b0;
            Wr_done  <= 1'b0;
            case (state)
                // IDLE and RD share their exits. RD re-reads on every cycle
                // in which the read strobes stay asserted.
                IDLE, RD: begin
                    if (wr_req) begin
                        state <= WR1;
                    end else if (rd_req) begin
                        state    <= RD;
                        Rd_valid <= 1'b1;
                        Data_out <= rd_data;
                    end else begin
                        state <= IDLE;
                    end
                end
                // WR1 commits (see 'commit') and moves on. It aborts on any
                // other strobe pattern.
                WR1: begin
                    if (wr_req) begin
                        state   <= WR2;
                        Wr_done <= 1'b1;
                    end else begin
                        state <= IDLE;
                    end
                end
                // WR2 holds while WE stays low, but performs no further writes.
                WR2: begin
                    if (wr_req) begin
                        state   <= WR2;
                        Wr_done <= 1'b1;
                    end else begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_responder.sv
// Table-driven bench for mem_responder.
// Each row drives one cycle of strobes. Its expected outputs go into a
// scoreboard queue and are compared just after the following rising edge.
// Hand sequences cover reset behaviour.
module tb_mem_responder;

    logic        Clk = 1'b0;
    logic        Reset_n = 1'b1;
    logic        Mem_CE = 1'b1, Mem_OE = 1'b1, Mem_WE = 1'b1;
    logic        Mem_UB = 1'b0, Mem_LB = 1'b0;
    logic [15:0] Mem_addr = '0;
    logic [15:0] Data_in = '0;
    logic [15:0] Data_out;
    logic        Rd_valid, Wr_done, Mem_err;

    mem_responder #(.ADDR_W(8), .DATA_W(16)) dut (
        .Clk(Clk), .Reset_n(Reset_n),
        .Mem_CE(Mem_CE), .Mem_OE(Mem_OE), .Mem_WE(Mem_WE),
        .Mem_UB(Mem_UB), .Mem_LB(Mem_LB),
        .Mem_addr(Mem_addr), .Data_in(Data_in),
        .Data_out(Data_out), .Rd_valid(Rd_valid),
        .Wr_done(Wr_done), .Mem_err(Mem_err)
    );

    always #5 Clk = ~Clk;

    typedef struct {
        logic        ce, oe, we, ub, lb;
        logic [15:0] addr, din;
        logic [15:0] dout;
        logic        rv, wd, err;
    } vec_t;

    typedef struct {
        int          idx;
        logic [15:0] dout;
        logic        rv, wd, err;
    } exp_t;

    vec_t tbl[$];
    exp_t sb[$];
    int   n_vec = 0;
    int   n_bad = 0;

    function automatic void add(input logic ce, oe, we, ub, lb,
                                input logic [15:0] addr, din, dout,
                                input logic rv, wd, err);
        vec_t v;
        v.ce = ce; v.oe = oe; v.we = we; v.ub = ub; v.lb = lb;
        v.addr = addr; v.din = din; v.dout = dout;
        v.rv = rv; v.wd = wd; v.err = err;
        tbl.push_back(v);
    endfunction

    // Bus-idle row (CE high). Data_out must keep dout.
    function automatic void idle(input logic [15:0] dout, input logic wd);
        add(1, 1, 1, 0, 0, 16'h0000, 16'h0000, dout, 0, wd, 0);
    endfunction

    task automatic check(input string name, input logic [15:0] dout,
                         input logic rv, wd, err);
        n_vec++;
        if (Data_out !== dout || Rd_valid !== rv || Wr_done !== wd || Mem_err !== err) begin
            n_bad++;
            $display("FAIL %s: got dout=%h rv=%b wd=%b err=%b, want dout=%h rv=%b wd=%b err=%b",
                     name, Data_out, Rd_valid, Wr_done, Mem_err, dout, rv, wd, err);
        end
    endtask

    task automatic apply(input int idx);
        exp_t e;
        @(negedge Clk);
        Mem_CE = tbl[idx].ce; Mem_OE = tbl[idx].oe; Mem_WE = tbl[idx].we;
        Mem_UB = tbl[idx].ub; Mem_LB = tbl[idx].lb;
        Mem_addr = tbl[idx].addr; Data_in = tbl[idx].din;
        e.idx = idx; e.dout = tbl[idx].dout;
        e.rv = tbl[idx].rv; e.wd = tbl[idx].wd; e.err = tbl[idx].err;
        sb.push_back(e);
        @(posedge Clk);
        #1;
        e = sb.pop_front();
        check($sformatf("vec%0d", e.idx), e.dout, e.rv, e.wd, e.err);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] last_dout;
        logic [15:0] w05;

        //  ce oe we ub lb  addr     din       dout     rv wd err
        idle(16'h0000, 0);                                          // 0
        // Write BEEF to 0x05: Wr_done appears in the third cycle.
        add(0, 1, 0, 0, 0, 16'h0005, 16'hBEEF, 16'h0000, 0, 0, 0);  // 1 -> WR1
        add(0, 1, 0, 0, 0, 16'h0005, 16'hBEEF, 16'h0000, 0, 1, 0);  // 2 commit
        idle(16'h0000, 0);                                          // 3
        // Two-cycle read of 0x05.
        add(0, 0, 1, 0, 0, 16'h0005, 16'h0000, 16'hBEEF, 1, 0, 0);  // 4
        add(0, 0, 1, 0, 0, 16'h0005, 16'h0000, 16'hBEEF, 1, 0, 0);  // 5
        idle(16'hBEEF, 0);                                          // 6
        // Aborted write: WE low for a single cycle only.
        add(0, 1, 0, 0, 0, 16'h0005, 16'h1234, 16'hBEEF, 0, 0, 0);  // 7
        idle(16'hBEEF, 0);                                          // 8
        add(0, 0, 1, 0, 0, 16'h0005, 16'h0000, 16'hBEEF, 1, 0, 0);  // 9
        idle(16'hBEEF, 0);                                          // 10
        // Alias: 0x0103 maps to word 3. The read follows the write directly.
        add(0, 1, 0, 0, 0, 16'h0103, 16'hA5A5, 16'hBEEF, 0, 0, 0);  // 11
        add(0, 1, 0, 0, 0, 16'h0103, 16'hA5A5, 16'hBEEF, 0, 1, 0);  // 12
        add(0, 0, 1, 0, 0, 16'h0003, 16'h0000, 16'hBEEF, 0, 0, 0);  // 13 WR2->IDLE
        add(0, 0, 1, 0, 0, 16'h0003, 16'h0000, 16'hA5A5, 1, 0, 0);  // 14
        idle(16'hA5A5, 0);                                          // 15
        // WR2 held a third cycle must not write its new data.
        add(0, 1, 0, 0, 0, 16'h0000, 16'h5A01, 16'hA5A5, 0, 0, 0);  // 16
        add(0, 1, 0, 0, 0, 16'h0000, 16'h5A01, 16'hA5A5, 0, 1, 0);  // 17
        add(0, 1, 0, 0, 0, 16'h0000, 16'hFFFF, 16'hA5A5, 0, 1, 0);  // 18 hold
        idle(16'hA5A5, 0);                                          // 19
        add(0, 0, 1, 0, 0, 16'h0100, 16'h0000, 16'h5A01, 1, 0, 0);  // 20 alias 0
        idle(16'h5A01, 0);                                          // 21
        // OE and WE both low: the write wins and Mem_err pulses each cycle.
        add(0, 0, 0, 0, 0, 16'h0007, 16'h0F0F, 16'h5A01, 0, 0, 1);  // 22
        add(0, 0, 0, 0, 0, 16'h0007, 16'h0F0F, 16'h5A01, 0, 1, 1);  // 23
        idle(16'h5A01, 0);                                          // 24
        add(0, 0, 1, 0, 0, 16'h0007, 16'h0000, 16'h0F0F, 1, 0, 0);  // 25
        // RD -> WR1, then CE high aborts the write.
        add(0, 1, 0, 0, 0, 16'h0007, 16'h1111, 16'h0F0F, 0, 0, 0);  // 26
        add(1, 1, 0, 0, 0, 16'h0007, 16'h1111, 16'h0F0F, 0, 0, 0);  // 27
        add(0, 0, 1, 0, 0, 16'h0007, 16'h0000, 16'h0F0F, 1, 0, 0);  // 28
        add(1, 0, 1, 0, 0, 16'h0007, 16'h0000, 16'h0F0F, 0, 0, 0);  // 29
`ifdef MEM_RESPONDER_BYTE_EN
        // Write only the low byte of 0x05 (UB off): BEEF becomes BE22.
        add(0, 1, 0, 1, 0, 16'h0005, 16'h1122, 16'h0F0F, 0, 0, 0);  // 30
        add(0, 1, 0, 1, 0, 16'h0005, 16'h1122, 16'h0F0F, 0, 1, 0);  // 31
        idle(16'h0F0F, 0);                                          // 32
        add(0, 0, 1, 0, 0, 16'h0005, 16'h0000, 16'hBE22, 1, 0, 0);  // 33
        add(0, 0, 1, 0, 1, 16'h0005, 16'h0000, 16'hBE00, 1, 0, 0);  // 34 LB off
        idle(16'hBE00, 0);                                          // 35
        last_dout = 16'hBE00;
        w05       = 16'hBE22;
`else
        // UB/LB are ignored: full-word write and read with both lanes off.
        add(0, 1, 0, 1, 1, 16'h0009, 16'h3C3C, 16'h0F0F, 0, 0, 0);  // 30
        add(0, 1, 0, 1, 1, 16'h0009, 16'h3C3C, 16'h0F0F, 0, 1, 0);  // 31
        idle(16'h0F0F, 0);                                          // 32
        add(0, 0, 1, 1, 1, 16'h0009, 16'h0000, 16'h3C3C, 1, 0, 0);  // 33
        idle(16'h3C3C, 0);                                          // 34
        last_dout = 16'h3C3C;
        w05       = 16'hBEEF;
`endif

        // Power-on reset through a real falling edge.
        #1 Reset_n = 1'b0;
        repeat (2) @(posedge Clk);
        #1;
        check("reset_state", 16'h0000, 0, 0, 0);
        @(negedge Clk);
        Reset_n = 1'b1;

        for (int i = 0; i < tbl.size(); i++) apply(i);

        // Reset during WR1 (with a collision so that Mem_err is high going in).
        @(negedge Clk);
        Mem_CE = 0; Mem_OE = 0; Mem_WE = 0; Mem_UB = 0; Mem_LB = 0;
        Mem_addr = 16'h0005; Data_in = 16'hDEAD;
        @(posedge Clk);
        #1;
        check("pre_reset_wr1", last_dout, 0, 0, 1);
        #2 Reset_n = 1'b0;
        #1;
        check("reset_async", 16'h0000, 0, 0, 0);
        @(posedge Clk);
        #1;
        check("reset_held", 16'h0000, 0, 0, 0);
        @(negedge Clk);
        Reset_n = 1'b1;
        Mem_CE = 1; Mem_OE = 1; Mem_WE = 1;
        tbl.delete();
        add(0, 0, 1, 0, 0, 16'h0005, 16'h0000, w05, 1, 0, 0);
        add(0, 0, 1, 0, 0, 16'h0005, 16'h0000, w05, 1, 0, 0);
        idle(w05, 0);
        for (int i = 0; i < tbl.size(); i++) apply(i);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/mem_responder.md
MEM_RESPONDER -- requirements
Module: mem_responder

Interface
REQ-001 Parameter ADDR_W, default 8, number of word-address bits decoded; storage depth is 2^ADDR_W words.
REQ-002 Parameter DATA_W, default 16, word width in bits; it SHALL remain 16 when MEM_RESPONDER_BYTE_EN is defined.
REQ-003 Clk  input  1  single clock; all state updates on rising edge.
REQ-004 Reset_n  input  1  asynchronous, active-low reset.
REQ-005 Mem_CE  input  1  chip enable, active-low.
REQ-006 Mem_OE  input  1  output (read) enable, active-low.
REQ-007 Mem_WE  input  1  write enable, active-low.
REQ-008 Mem_UB  input  1  upper-byte lane enable, active-low.
REQ-009 Mem_LB  input  1  lower-byte lane enable, active-low.
REQ-010 Mem_addr  input  16  word address; only bits [ADDR_W-1:0] are decoded.
REQ-011 Data_in  input  DATA_W  write data from the initiator's MDR.
REQ-012 Data_out  output  DATA_W  registered read data.
REQ-013 Rd_valid  output  1  Data_out holds data for the current read.
REQ-014 Wr_done  output  1  high in the cycle after a write commits.
REQ-015 Mem_err  output  1  one-cycle pulse on an illegal strobe combination.

Function
REQ-016 The FSM SHALL have exactly four states: IDLE, RD, WR1, WR2.
REQ-017 IDLE -> WR1 when CE=0 and WE=0 are sampled; IDLE -> RD when CE=0, OE=0 and WE=1; otherwise IDLE holds.
REQ-018 On every edge that enters or remains in RD, Data_out SHALL load mem[Mem_addr[ADDR_W-1:0]]; Rd_valid=1 while in RD, so data is valid during the second OE-low cycle.
REQ-019 RD stays while CE=0 and OE=0 and WE=1 (continuous re-read); RD -> WR1 if WE=0 with CE=0; otherwise RD -> IDLE.
REQ-020 WR1 with CE=0 and WE=0 sampled SHALL commit Data_in to mem[addr] at that edge and go to WR2; otherwise WR1 -> IDLE, and no write occurs (abort).
REQ-021 A write SHALL therefore require WE low for two consecutive sampled cycles; data and address are sampled at the commit edge.
REQ-022 WR2: Wr_done=1; WR2 stays, without further writes, while CE=0 and WE=0; otherwise WR2 -> IDLE.
REQ-023 CE=1 sampled in any state SHALL force IDLE at the next edge.
REQ-024 CE=0 with OE=0 and WE=0 SHALL be treated as a write (write priority); Mem_err SHALL pulse for one cycle at each such sampled cycle.
REQ-025 Address bits above ADDR_W-1 SHALL be ignored (aliasing wrap-around); address 0x0100 with ADDR_W=8 maps to word 0.
REQ-026 Outside RD, Data_out SHALL hold its last value and Rd_valid=0.
REQ-027 Read-after-write to the same address in back-to-back accesses SHALL return the newly committed data.

Reset
REQ-028 Reset_n=0 SHALL immediately force IDLE, Data_out=0, Rd_valid=0, Wr_done=0, Mem_err=0.
REQ-029 The storage array SHALL NOT be reset; its contents are undefined until written.
REQ-030 Reset asserted during WR1 SHALL abort the pending write, leaving memory unchanged.

Configuration
REQ-031 Macro MEM_RESPONDER_BYTE_EN defined: a commit writes byte [15:8] only if UB=0 and byte [7:0] only if LB=0; a read returns 0x00 in any lane whose enable is 1.
REQ-032 Macro MEM_RESPONDER_BYTE_EN undefined: UB and LB SHALL be ignored; every commit writes and every read returns the full word.

Verification
REQ-033 Write: CE=0, WE=0 for 2 cycles, addr 0x05, Data_in 0xBEEF -> Wr_done=1 in cycle 3; a subsequent 2-cycle OE read of 0x05 gives Data_out=0xBEEF with Rd_valid=1 in cycle 2.
REQ-034 Aborted write: WE low for 1 cycle to addr 0x05, Data_in 0x1234 -> Wr_done remains 0; a later read still returns 0xBEEF.
REQ-035 Alias: write 0xA5A5 to addr 0x0103 (ADDR_W=8) -> a read of addr 0x0003 returns 0xA5A5.
REQ-036 Conflict: CE=0, OE=0, WE=0 for 2 cycles, Data_in 0x0F0F -> Mem_err pulses each sampled cycle, the write commits, Rd_valid stays 0.
REQ-037 Reset mid-write: Reset_n low during WR1 -> all outputs 0 immediately; the target word is unchanged.
REQ-038 BYTE_EN on: word 0xBEEF, then write 0x1122 with UB=1, LB=0 -> a full read returns 0xBE22; with LB=1 a read returns 0xBE00.
